// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared pattern codes, FSM states and colour-bar table for the HDMI pattern source
package hdmi_pkg;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Eight equal-width bars, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/hdmi_timing_ctr.sv
// hdmi_timing_ctr: raster h/v counters with unregistered active/sync region flags
module hdmi_timing_ctr
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          run_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          origin_o,
  output logic          wrap_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;

  assign h_last = h_q == HW'(H_TOTAL - 1);
  assign v_last = v_q == VW'(V_TOTAL - 1);

  // Counters sit at the origin whenever the source is not running.
  always_comb begin
    h_d = (!run_i || h_last) ? '0 : h_q + 1'b1;
    v_d = !run_i ? '0 : !h_last ? v_q : v_last ? '0 : v_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign de_o     = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
  assign hs_o     = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_o     = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign origin_o = (h_q == '0) && (v_q == '0);
  assign wrap_o   = h_last && v_last;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: HDMI-style video timing plus selectable test pattern on one pixel clock
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        hdmi_clk,
  input  logic        hdmi_rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        hdmi_de,
  output logic        hdmi_hs,
  output logic        hdmi_vs,
  output logic [7:0]  hdmi_r,
  output logic [7:0]  hdmi_g,
  output logic [7:0]  hdmi_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;

  state_e        state_q;
  pattern_e      pat_q, pat_d;
  logic [23:0]   solid_q, solid_d, rgb_q, rgb_d, pat_rgb;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic          run, t_de, t_hs, t_vs, origin, wrap;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [2:0]    bar;

  assign run = state_q == ST_RUN;

  hdmi_timing_ctr #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i   (hdmi_clk),
    .rst_ni  (hdmi_rst_n),
    .run_i   (run),
    .h_o     (h),
    .v_o     (v),
    .de_o    (t_de),
    .hs_o    (t_hs),
    .vs_o    (t_vs),
    .origin_o(origin),
    .wrap_o  (wrap)
  );

  // Pattern settings take effect at the frame origin so every pixel of a frame shares one setting.
  always_comb begin
    pat_d   = (run && origin) ? pattern_e'(pattern_sel) : pat_q;
    solid_d = (run && origin) ? solid_rgb : solid_q;
    bar     = 3'(h / HW'(BAR_W));
    pat_rgb = pat_d == PAT_BARS  ? BAR_RGB[bar] :
              pat_d == PAT_RAMP  ? {3{8'(h)}} :
              pat_d == PAT_CHECK ? {24{h[3] ^ v[3]}} : solid_d;
    de_d    = run && t_de;
    hs_d    = (run && t_hs) ? HS_POL : ~HS_POL;
    vs_d    = (run && t_vs) ? VS_POL : ~VS_POL;
    fs_d    = run && origin;
    rgb_d   = de_d ? pat_rgb : '0;
  end

  // Run/idle FSM and output registers; a frame always finishes before dropping to idle.
  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_BARS;
      solid_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= run ? ((wrap && !enable) ? ST_IDLE : ST_RUN) : (enable ? ST_RUN : ST_IDLE);
      pat_q   <= pat_d;
      solid_q <= solid_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hdmi_de     = de_q;
  assign hdmi_hs     = hs_q;
  assign hdmi_vs     = vs_q;
  assign hdmi_r      = rgb_q[23:16];
  assign hdmi_g      = rgb_q[15:8];
  assign hdmi_b      = rgb_q[7:0];
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: scoreboard bench with a frame-position reference model for two DUT variants
module tb_hdmi_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VF = 1, VS = 1, VB = 1;
  localparam int VACT [2] = '{8, 16};
  localparam logic POL [2] = '{1'b1, 1'b0};
  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        fs;
  } px_t;

  typedef struct packed {
    px_t a;
    px_t b;
  } pair_t;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'd0;
  logic        de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  int          checks = 0, passes = 0, fs_seen = 0;
  pair_t       sb[$];
  bit          run_m [2];
  int          p_m [2];
  logic [1:0]  pat_m [2];
  logic [23:0] sol_m [2];

  always #5 clk = ~clk;

  hdmi_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(8), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_a (
    .hdmi_clk(clk), .hdmi_rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .hdmi_de(de_a), .hdmi_hs(hs_a), .hdmi_vs(vs_a),
    .hdmi_r(r_a), .hdmi_g(g_a), .hdmi_b(b_a), .frame_start(fs_a)
  );

  hdmi_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(16), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .hdmi_clk(clk), .hdmi_rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .hdmi_de(de_b), .hdmi_hs(hs_b), .hdmi_vs(vs_b),
    .hdmi_r(r_b), .hdmi_g(g_b), .hdmi_b(b_b), .frame_start(fs_b)
  );

  function automatic px_t idle_px(logic pol);
    px_t e;
    e.de = 1'b0; e.hs = ~pol; e.vs = ~pol; e.rgb = 24'd0; e.fs = 1'b0;
    return e;
  endfunction

  function automatic px_t model_px(int h, int v, int vact, logic pol, logic [1:0] pat, logic [23:0] solid);
    px_t e;
    bit act;
    act   = (h < HA) && (v < vact);
    e.de  = act;
    e.hs  = (h >= HA + HF && h < HA + HF + HS) ? pol : ~pol;
    e.vs  = (v >= vact + VF && v < vact + VF + VS) ? pol : ~pol;
    e.fs  = (h == 0) && (v == 0);
    e.rgb = !act ? 24'd0 :
            pat == 2'd0 ? BARS[h / (HA / 8)] :
            pat == 2'd1 ? {3{8'(h % 256)}} :
            pat == 2'd2 ? ((((h / 8) + (v / 8)) % 2) == 1 ? 24'hFFFFFF : 24'h000000) : solid;
    return e;
  endfunction

  task automatic chk(string nm, px_t got, px_t exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s t=%0t got de=%b hs=%b vs=%b rgb=%h fs=%b required de=%b hs=%b vs=%b rgb=%h fs=%b",
               nm, $time, got.de, got.hs, got.vs, got.rgb, got.fs, exp.de, exp.hs, exp.vs, exp.rgb, exp.fs);
    else passes++;
  endtask

  task automatic chk_int(string nm, int got, int exp);
    checks++;
    if (got != exp) $display("FAIL %s got %0d required %0d", nm, got, exp);
    else passes++;
  endtask

  task automatic first_de_latency(string nm);
    int lat;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (de_a) begin
        lat = i;
        break;
      end
    end
    chk_int(nm, lat, 2);
  endtask

  // Reference model: each running source walks a flat pixel index through one frame.
  initial forever begin : model
    px_t   e [2];
    pair_t pr;
    int    ft;
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        run_m[k] = 1'b0;
        p_m[k]   = 0;
        e[k]     = idle_px(POL[k]);
      end else if (run_m[k]) begin
        ft = HT * (VACT[k] + VF + VS + VB);
        if (p_m[k] == 0) begin
          pat_m[k] = pattern_sel;
          sol_m[k] = solid_rgb;
        end
        e[k] = model_px(p_m[k] % HT, p_m[k] / HT, VACT[k], POL[k], pat_m[k], sol_m[k]);
        if (p_m[k] == ft - 1) begin
          p_m[k]   = 0;
          run_m[k] = enable;
        end else p_m[k]++;
      end else begin
        e[k] = idle_px(POL[k]);
        if (enable) begin
          run_m[k] = 1'b1;
          p_m[k]   = 0;
        end
      end
    end
    if (!rst_n) sb.delete();
    pr.a = e[0];
    pr.b = e[1];
    sb.push_back(pr);
  end

  // Monitor: compares every presented output cycle against the oldest expectation.
  initial forever begin : monitor
    pair_t pr;
    @(negedge clk);
    if (fs_a || fs_b) fs_seen++;
    if (sb.size() > 0) begin
      pr = sb.pop_front();
      chk("dut_a_px", {de_a, hs_a, vs_a, r_a, g_a, b_a, fs_a}, pr.a);
      chk("dut_b_px", {de_b, hs_b, vs_b, r_b, g_b, b_b, fs_b}, pr.b);
    end
  end

  initial begin
    int vs_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk_int("no_frame_start_idle", fs_seen, 0);
    pattern_sel = 2'd0;
    enable = 1'b1;
    first_de_latency("first_de_latency");
    repeat (30) @(negedge clk);
    enable = 1'b0;
    vs_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (vs_a) vs_cnt++;
    end
    chk_int("vs_lines_after_drop", vs_cnt, HT * VS);
    chk_int("idle_after_drop", {31'd0, de_a | de_b | fs_a | fs_b}, 0);
    enable = 1'b1;
    for (int f = 0; f < 14; f++) begin
      repeat ($urandom_range(20, 300)) @(negedge clk);
      pattern_sel = (f < 8) ? 2'(f) : 2'($urandom);
      solid_rgb   = 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 600)) @(negedge clk);
        enable = 1'b1;
      end
    end
    repeat (45) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_async_a", {de_a, hs_a, vs_a, r_a, g_a, b_a, fs_a}, idle_px(1'b1));
    chk("reset_async_b", {de_b, hs_b, vs_b, r_b, g_b, b_b, fs_b}, idle_px(1'b0));
    repeat (2) @(negedge clk);
    pattern_sel = 2'd2;
    rst_n = 1'b1;
    first_de_latency("first_de_after_reset");
    repeat (900) @(negedge clk);
    enable = 1'b0;
    repeat (500) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
